// File: rtl/ysyx_23060240_lsu_pkg.sv
// Shared encodings for the ysyx_23060240 load/store unit: access sizes, error codes, FSM states.
package ysyx_23060240_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } size_e;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ALIGN   = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_SIZE    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RSP,
    ST_RESP
  } state_e;

  // An access is aligned when the address is a multiple of its byte count.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [2:0] lowAddr);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lowAddr[0];
      SZ_WORD: return |lowAddr[1:0];
      default: return |lowAddr;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_23060240_lsu_if.sv
// Core-side (EX -> WB) and memory-side bus interfaces of the ysyx_23060240 load/store unit.
interface ysyx_23060240_lsu_core_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              in_valid;
  logic              in_ready;
  logic              in_we;
  logic [1:0]        in_size;
  logic              in_unsigned;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_wdata;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_rdata;
  logic              out_err;
  logic [1:0]        out_err_code;

  modport master (
    output in_valid, in_we, in_size, in_unsigned, in_addr, in_wdata, out_ready,
    input  in_ready, out_valid, out_rdata, out_err, out_err_code
  );

  modport slave (
    input  in_valid, in_we, in_size, in_unsigned, in_addr, in_wdata, out_ready,
    output in_ready, out_valid, out_rdata, out_err, out_err_code
  );
endinterface

interface ysyx_23060240_lsu_mem_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  localparam int STRB_W = DATA_W / 8;

  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [DATA_W-1:0] mem_req_wdata;
  logic [STRB_W-1:0] mem_req_wstrb;
  logic              mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_rdata;

  modport master (
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );

  modport slave (
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
  );
endinterface

// File: rtl/ysyx_23060240_lsu_align.sv
// Byte-lane steering: store strobes/shifted data from (size, offset), and load extraction with extension.
module ysyx_23060240_lsu_align
  import ysyx_23060240_lsu_pkg::*;
#(
  parameter int  DATA_W = 32,
  localparam int STRB_W = DATA_W / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic [1:0]        i_stSize,
  input  logic [OFF_W-1:0]  i_stOff,
  input  logic [DATA_W-1:0] i_stData,
  output logic [STRB_W-1:0] o_wstrb,
  output logic [DATA_W-1:0] o_wdata,
  input  logic [1:0]        i_ldSize,
  input  logic [OFF_W-1:0]  i_ldOff,
  input  logic              i_ldUnsigned,
  input  logic [DATA_W-1:0] i_ldData,
  output logic [DATA_W-1:0] o_ldData
);

  logic [STRB_W-1:0] w_baseStrb;
  logic [DATA_W-1:0] w_byteMask;
  logic [DATA_W-1:0] w_ldShifted;

  // Unused lanes of the store data are zeroed so the bus never carries stale bytes.
  always_comb begin
    w_baseStrb = '1;
    case (i_stSize)
      SZ_BYTE: w_baseStrb = STRB_W'(8'h01);
      SZ_HALF: w_baseStrb = STRB_W'(8'h03);
      SZ_WORD: w_baseStrb = STRB_W'(8'h0F);
      default: w_baseStrb = '1;
    endcase
    w_byteMask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      w_byteMask[8*i +: 8] = {8{w_baseStrb[i]}};
    end
    o_wstrb = w_baseStrb << i_stOff;
    o_wdata = (i_stData & w_byteMask) << {i_stOff, 3'b000};
  end

  always_comb begin
    w_ldShifted = i_ldData >> {i_ldOff, 3'b000};
    o_ldData    = w_ldShifted;
    case (i_ldSize)
      SZ_BYTE: o_ldData = i_ldUnsigned ? DATA_W'(w_ldShifted[7:0])  : DATA_W'($signed(w_ldShifted[7:0]));
      SZ_HALF: o_ldData = i_ldUnsigned ? DATA_W'(w_ldShifted[15:0]) : DATA_W'($signed(w_ldShifted[15:0]));
      SZ_WORD: o_ldData = i_ldUnsigned ? DATA_W'(w_ldShifted[31:0]) : DATA_W'($signed(w_ldShifted[31:0]));
      default: o_ldData = w_ldShifted;
    endcase
  end

endmodule

// File: rtl/ysyx_23060240_lsu.sv
// Multi-cycle load/store unit with registered request/response memory bus.
// Optional perf counters: define YSYX_23060240_LSU_PERF_EN.
module ysyx_23060240_lsu
  import ysyx_23060240_lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  ysyx_23060240_lsu_core_if.slave core,
  ysyx_23060240_lsu_mem_if.master mem
`ifdef YSYX_23060240_LSU_PERF_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_stall_cyc
`endif
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e            r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [OFF_W-1:0]  r_off;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_inReady;
  logic              r_outValid;
  logic [DATA_W-1:0] r_outRdata;
  logic              r_outErr;
  logic [1:0]        r_outErrCode;
  logic              r_memReqValid;
  logic              r_memReqWe;
  logic [ADDR_W-1:0] r_memReqAddr;
  logic [DATA_W-1:0] r_memReqWdata;
  logic [STRB_W-1:0] r_memReqWstrb;

  logic              w_illegal;
  logic              w_misaligned;
  logic [STRB_W-1:0] w_wstrb;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_ldData;

  assign w_illegal    = (core.in_size == SZ_DWORD) && (DATA_W != 64);
  assign w_misaligned = isMisaligned(core.in_size, core.in_addr[2:0]);

  ysyx_23060240_lsu_align #(.DATA_W(DATA_W)) u_align (
    .i_stSize     (core.in_size),
    .i_stOff      (core.in_addr[OFF_W-1:0]),
    .i_stData     (core.in_wdata),
    .o_wstrb      (w_wstrb),
    .o_wdata      (w_wdata),
    .i_ldSize     (r_size),
    .i_ldOff      (r_off),
    .i_ldUnsigned (r_unsigned),
    .i_ldData     (mem.mem_rsp_rdata),
    .o_ldData     (w_ldData)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_we          <= 1'b0;
      r_size        <= 2'd0;
      r_unsigned    <= 1'b0;
      r_off         <= '0;
      r_cnt         <= '0;
      r_inReady     <= 1'b1;
      r_outValid    <= 1'b0;
      r_outRdata    <= '0;
      r_outErr      <= 1'b0;
      r_outErrCode  <= ERR_NONE;
      r_memReqValid <= 1'b0;
      r_memReqWe    <= 1'b0;
      r_memReqAddr  <= '0;
      r_memReqWdata <= '0;
      r_memReqWstrb <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (core.in_valid && r_inReady) begin
            r_inReady  <= 1'b0;
            r_we       <= core.in_we;
            r_size     <= core.in_size;
            r_unsigned <= core.in_unsigned;
            r_off      <= core.in_addr[OFF_W-1:0];
            // Rejected requests skip the bus entirely and answer on the next cycle.
            if (w_illegal || w_misaligned) begin
              r_state      <= ST_RESP;
              r_outValid   <= 1'b1;
              r_outRdata   <= '0;
              r_outErr     <= 1'b1;
              r_outErrCode <= w_illegal ? ERR_SIZE : ERR_ALIGN;
            end else begin
              r_state       <= ST_REQ;
              r_memReqValid <= 1'b1;
              r_memReqWe    <= core.in_we;
              r_memReqAddr  <= {core.in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              r_memReqWdata <= core.in_we ? w_wdata : '0;
              r_memReqWstrb <= core.in_we ? w_wstrb : '0;
            end
          end
        end
        ST_REQ: begin
          if (mem.mem_req_ready) begin
            r_memReqValid <= 1'b0;
            r_cnt         <= '0;
            r_state       <= ST_WAIT_RSP;
          end
        end
        ST_WAIT_RSP: begin
          if (mem.mem_rsp_valid) begin
            r_state      <= ST_RESP;
            r_outValid   <= 1'b1;
            r_outRdata   <= r_we ? '0 : w_ldData;
            r_outErr     <= 1'b0;
            r_outErrCode <= ERR_NONE;
          end else if ((TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1))) begin
            r_state      <= ST_RESP;
            r_outValid   <= 1'b1;
            r_outRdata   <= '0;
            r_outErr     <= 1'b1;
            r_outErrCode <= ERR_TIMEOUT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (core.out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign core.in_ready     = r_inReady;
  assign core.out_valid    = r_outValid;
  assign core.out_rdata    = r_outRdata;
  assign core.out_err      = r_outErr;
  assign core.out_err_code = r_outErrCode;
  assign mem.mem_req_valid = r_memReqValid;
  assign mem.mem_req_we    = r_memReqWe;
  assign mem.mem_req_addr  = r_memReqAddr;
  assign mem.mem_req_wdata = r_memReqWdata;
  assign mem.mem_req_wstrb = r_memReqWstrb;

`ifdef YSYX_23060240_LSU_PERF_EN
  // Only bus responses count as successful; timeouts and rejected requests do not.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_loads     <= '0;
      perf_stores    <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if ((r_state == ST_REQ) || (r_state == ST_WAIT_RSP)) begin
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      end
      if ((r_state == ST_WAIT_RSP) && mem.mem_rsp_valid) begin
        if (r_we) perf_stores <= perf_stores + 32'd1;
        else      perf_loads  <= perf_loads + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_23060240_lsu.sv
// Randomized self-checking bench for ysyx_23060240_lsu against a byte-level reference model.
module tb_ysyx_23060240_lsu;

  localparam int TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   expLoads = 0;
  int   expStores = 0;

  logic [31:0] lastRdata;
  logic [1:0]  lastCode;
  logic [31:0] lastReqAddr;
  logic [31:0] lastReqWdata;
  logic [3:0]  lastReqWstrb;

`ifdef YSYX_23060240_LSU_PERF_EN
  logic [31:0] perfLoads;
  logic [31:0] perfStores;
  logic [31:0] perfStallCyc;
`endif

  always #5 clk = ~clk;

  ysyx_23060240_lsu_core_if #(.ADDR_W(32), .DATA_W(32)) coreBus ();
  ysyx_23060240_lsu_mem_if  #(.ADDR_W(32), .DATA_W(32)) memBus ();

  ysyx_23060240_lsu #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst  (rst),
    .core (coreBus),
    .mem  (memBus)
`ifdef YSYX_23060240_LSU_PERF_EN
    ,
    .perf_loads     (perfLoads),
    .perf_stores    (perfStores),
    .perf_stall_cyc (perfStallCyc)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Byte-by-byte model of what the unit should produce for one access.
  function automatic void refModel(
    input  bit we, input logic [1:0] size, input bit uns, input logic [31:0] addr,
    input  logic [31:0] wdata, input logic [31:0] memData, input bit timedOut,
    output logic [1:0] code, output logic [31:0] rdata,
    output logic [31:0] reqAddr, output logic [31:0] reqWdata, output logic [3:0] reqWstrb);
    int nBytes;
    int off;
    longint value;
    nBytes   = 1 << size;
    off      = int'(addr[1:0]);
    code     = 2'd0;
    rdata    = 32'd0;
    reqAddr  = addr - 32'(off);
    reqWdata = 32'd0;
    reqWstrb = 4'd0;
    value    = 0;
    if (size == 2'd3) code = 2'd3;
    else if ((addr % nBytes) != 0) code = 2'd1;
    else begin
      if (we) begin
        for (int i = 0; i < nBytes; i++) begin
          reqWstrb[off + i] = 1'b1;
          reqWdata[8*(off + i) +: 8] = wdata[8*i +: 8];
        end
      end else begin
        for (int i = 0; i < nBytes; i++) begin
          value = value + (longint'(memData[8*(off + i) +: 8]) << (8*i));
        end
        if (!uns && value >= (64'sd1 << (8*nBytes - 1))) value = value - (64'sd1 << (8*nBytes));
        rdata = 32'(value);
      end
      if (timedOut) begin
        code  = 2'd2;
        rdata = 32'd0;
      end
    end
  endfunction

  // Runs one full request through the unit, playing the memory with the given latencies.
  task automatic applyStimulus(
    input bit we, input logic [1:0] size, input bit uns, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [31:0] memData,
    input int reqLat, input int rspLat, input int outLat);
    logic [1:0]  eCode;
    logic [31:0] eRdata, eAddr, eWdata;
    logic [3:0]  eStrb;
    int          waited;
    refModel(we, size, uns, addr, wdata, memData, rspLat >= TIMEOUT, eCode, eRdata, eAddr, eWdata, eStrb);

    checkOutput("in_ready_idle", coreBus.in_ready, 1);
    coreBus.in_valid    = 1'b1;
    coreBus.in_we       = we;
    coreBus.in_size     = size;
    coreBus.in_unsigned = uns;
    coreBus.in_addr     = addr;
    coreBus.in_wdata    = wdata;
    @(negedge clk);
    coreBus.in_valid = 1'b0;
    checkOutput("in_ready_busy", coreBus.in_ready, 0);
    lastReqAddr  = memBus.mem_req_addr;
    lastReqWdata = memBus.mem_req_wdata;
    lastReqWstrb = memBus.mem_req_wstrb;

    if (eCode == 2'd1 || eCode == 2'd3) begin
      checkOutput("err_no_req", memBus.mem_req_valid, 0);
    end else begin
      for (int k = 0; k <= reqLat; k++) begin
        checkOutput("req_valid", memBus.mem_req_valid, 1);
        checkOutput("req_we", memBus.mem_req_we, we);
        checkOutput("req_addr", memBus.mem_req_addr, eAddr);
        checkOutput("req_wdata", memBus.mem_req_wdata, eWdata);
        checkOutput("req_wstrb", memBus.mem_req_wstrb, eStrb);
        checkOutput("out_valid_in_req", coreBus.out_valid, 0);
        if (k < reqLat) begin
          memBus.mem_rsp_valid = 1'($urandom_range(0, 1));
          memBus.mem_rsp_rdata = $urandom;
          coreBus.in_valid     = 1'($urandom_range(0, 1));
          coreBus.in_addr      = $urandom;
          @(negedge clk);
        end
      end
      memBus.mem_rsp_valid = 1'b0;
      coreBus.in_valid     = 1'b0;
      memBus.mem_req_ready = 1'b1;
      @(negedge clk);
      memBus.mem_req_ready = 1'b0;
      checkOutput("req_dropped", memBus.mem_req_valid, 0);

      waited = 0;
      while (waited < TIMEOUT + 3) begin
        if (waited == rspLat) begin
          memBus.mem_rsp_valid = 1'b1;
          memBus.mem_rsp_rdata = memData;
        end
        @(negedge clk);
        memBus.mem_rsp_valid = 1'b0;
        waited++;
        if (coreBus.out_valid) break;
      end
      checkOutput("rsp_latency", 64'(waited), 64'((rspLat >= TIMEOUT) ? TIMEOUT : rspLat + 1));
    end

    for (int k = 0; k <= outLat; k++) begin
      checkOutput("out_valid", coreBus.out_valid, 1);
      checkOutput("out_rdata", coreBus.out_rdata, eRdata);
      checkOutput("out_err", coreBus.out_err, eCode != 2'd0);
      checkOutput("out_err_code", coreBus.out_err_code, eCode);
      checkOutput("in_ready_resp", coreBus.in_ready, 0);
      if (k < outLat) begin
        memBus.mem_rsp_valid = 1'($urandom_range(0, 1));
        memBus.mem_rsp_rdata = $urandom;
        coreBus.in_valid     = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    lastRdata = coreBus.out_rdata;
    lastCode  = coreBus.out_err_code;
    memBus.mem_rsp_valid = 1'b0;
    coreBus.in_valid     = 1'b0;
    coreBus.out_ready    = 1'b1;
    @(negedge clk);
    coreBus.out_ready = 1'b0;
    checkOutput("out_valid_done", coreBus.out_valid, 0);
    checkOutput("in_ready_done", coreBus.in_ready, 1);
    if (eCode == 2'd0) begin
      if (we) expStores++;
      else    expLoads++;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  size;
    logic [31:0] addr;
    int          low;

    coreBus.in_valid     = 1'b0;
    coreBus.in_we        = 1'b0;
    coreBus.in_size      = 2'd0;
    coreBus.in_unsigned  = 1'b0;
    coreBus.in_addr      = 32'd0;
    coreBus.in_wdata     = 32'd0;
    coreBus.out_ready    = 1'b0;
    memBus.mem_req_ready = 1'b0;
    memBus.mem_rsp_valid = 1'b0;
    memBus.mem_rsp_rdata = 32'd0;

    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", coreBus.in_ready, 1);
    checkOutput("rst_out_valid", coreBus.out_valid, 0);
    checkOutput("rst_out_rdata", coreBus.out_rdata, 0);
    checkOutput("rst_out_err", coreBus.out_err, 0);
    checkOutput("rst_err_code", coreBus.out_err_code, 0);
    checkOutput("rst_req_valid", memBus.mem_req_valid, 0);
    checkOutput("rst_req_we", memBus.mem_req_we, 0);
    checkOutput("rst_req_addr", memBus.mem_req_addr, 0);
    checkOutput("rst_req_wdata", memBus.mem_req_wdata, 0);
    checkOutput("rst_req_wstrb", memBus.mem_req_wstrb, 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'd0, 32'h80FF_1234, 0, 0, 0);
    checkOutput("tp_lb_signed", lastRdata, 32'hFFFF_FF80);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h8000_0003, 32'd0, 32'h80FF_1234, 1, 1, 1);
    checkOutput("tp_lbu", lastRdata, 32'h0000_0080);

    applyStimulus(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_BEEF, 32'd0, 0, 0, 0);
    checkOutput("tp_sh_addr", lastReqAddr, 32'h8000_0000);
    checkOutput("tp_sh_wdata", lastReqWdata, 32'hBEEF_0000);
    checkOutput("tp_sh_wstrb", lastReqWstrb, 4'b1100);
    checkOutput("tp_sh_rdata", lastRdata, 32'd0);

    applyStimulus(1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'd0, 32'h1234_5678, 0, 0, 0);
    checkOutput("tp_misaligned_code", lastCode, 2'd1);

    applyStimulus(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'd0, 32'hCAFE_F00D, 5, 2, 3);
    checkOutput("tp_backpressure_rdata", lastRdata, 32'hCAFE_F00D);

    applyStimulus(1'b0, 2'd2, 1'b0, 32'h8000_0014, 32'd0, 32'h1111_2222, 0, 100, 2);
    checkOutput("tp_timeout_code", lastCode, 2'd2);
    memBus.mem_rsp_valid = 1'b1;
    memBus.mem_rsp_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    memBus.mem_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput("late_rsp_ignored", coreBus.out_valid, 0);
      @(negedge clk);
    end

    // Abandon a load mid-flight with reset, then make sure the unit is usable again.
    coreBus.in_valid = 1'b1;
    coreBus.in_we    = 1'b0;
    coreBus.in_size  = 2'd2;
    coreBus.in_addr  = 32'h8000_0020;
    @(negedge clk);
    coreBus.in_valid     = 1'b0;
    memBus.mem_req_ready = 1'b1;
    @(negedge clk);
    memBus.mem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_wait_in_ready", coreBus.in_ready, 1);
    checkOutput("rst_wait_out_valid", coreBus.out_valid, 0);
    checkOutput("rst_wait_req_valid", memBus.mem_req_valid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rst_wait_quiet", coreBus.out_valid, 0);
    end
    expLoads  = 0;
    expStores = 0;
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h8000_0022, 32'd0, 32'h8001_7FFF, 0, 1, 0);
    checkOutput("post_rst_load", lastRdata, 32'hFFFF_8001);

    for (int n = 0; n < 60; n++) begin
      size = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      low  = $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 7 && size != 2'd3) low = low & ~((1 << size) - 1);
      addr = 32'h8000_0000 | ($urandom & 32'h0000_0FFC) | 32'(low);
      applyStimulus(1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr,
                    $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 5), $urandom_range(0, 2));
    end

`ifdef YSYX_23060240_LSU_PERF_EN
    checkOutput("perf_loads", perfLoads, 32'(expLoads));
    checkOutput("perf_stores", perfStores, 32'(expStores));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
